simplebus_mem_slave: RTL and testbench



---
 rtl/simplebus_pkg.sv | 52 +++++
 rtl/simplebus_mem_array.sv | 28 ++
 rtl/simplebus_mem_slave.sv | 205 ++++++++++++++++++++
 tb/tb_simplebus_mem_slave.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebus_pkg.sv
// Shared SimpleBus definitions: command encodings, bus widths, slave FSM states
// and small helpers used by the memory slave and its storage array.
package simplebus_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int USER_W = 16;
    localparam int CMD_W  = 4;
    localparam int MASK_W = 8;

    localparam logic [3:0] CMD_READ        = 4'b0000;
    localparam logic [3:0] CMD_WRITE       = 4'b0001;
    localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
    localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
    localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;
    localparam logic [3:0] CMD_READ_LAST   = 4'b0110;
    localparam logic [3:0] CMD_WRITE_RESP  = 4'b0101;
    localparam logic [3:0] CMD_PROBE_MISS  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBURST = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_data,
                                                      input logic [DATA_W-1:0] new_data,
                                                      input logic [MASK_W-1:0] mask);
        logic [DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Latched request cmd plus "this is the final beat" -> response command.
    function automatic logic [CMD_W-1:0] resp_cmd_of(input logic [CMD_W-1:0] cmd,
                                                     input logic last_beat);
        case (cmd)
            CMD_READ:        return CMD_READ_LAST;
            CMD_READ_BURST:  return last_beat ? CMD_READ_LAST : CMD_READ;
            CMD_WRITE:       return CMD_WRITE_RESP;
            CMD_WRITE_BURST: return CMD_WRITE_RESP;
            default:         return CMD_PROBE_MISS;
        endcase
    endfunction

endpackage

// File: rtl/simplebus_mem_array.sv
// Word-addressed 64-bit storage with a byte-masked synchronous write port and a
// combinational read port. Contents are not initialised by reset.
module simplebus_mem_array
    import simplebus_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [MASK_W-1:0] wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**AW];

    // Byte-masked write, committed at the clock edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= merge_bytes(mem_q[waddr_i], wdata_i, wmask_i);
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simplebus_mem_slave.sv
// SimpleBus memory slave: single outstanding transaction, single/burst reads and
// writes, critical-word-first wrapping read bursts and programmable latency.
module simplebus_mem_slave
    import simplebus_pkg::*;
#(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int BEATS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_ready,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_bits_addr,
    input  logic [2:0]        req_bits_size,
    input  logic [CMD_W-1:0]  req_bits_cmd,
    input  logic [MASK_W-1:0] req_bits_wmask,
    input  logic [DATA_W-1:0] req_bits_wdata,
    input  logic [USER_W-1:0] req_bits_user,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [CMD_W-1:0]  resp_bits_cmd,
    output logic [DATA_W-1:0] resp_bits_rdata,
    output logic [USER_W-1:0] resp_bits_user
);

    localparam int BW = $clog2(BEATS);
    localparam int LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [USER_W-1:0] user_q, user_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [CMD_W-1:0]  resp_cmd_q, resp_cmd_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [USER_W-1:0] resp_user_q, resp_user_d;

    logic              acc_s, hs_s, we_s, last_s, load_s;
    logic [AW-1:0]     req_idx_s, waddr_s, raddr_s;
    logic [BW-1:0]     rcnt_s, nb_s;
    logic [DATA_W-1:0] rd_s;
    logic              unused_s;

    assign unused_s  = ^{req_bits_size, req_bits_addr[ADDR_W-1:AW+3], req_bits_addr[2:0]};
    assign req_idx_s = req_bits_addr[AW+2:3];
    assign acc_s     = req_valid && req_ready_q;
    assign hs_s      = resp_valid_q && resp_ready;

    // Read address of the beat about to be loaded: first beat from WAIT, next beat from RESP.
    assign rcnt_s  = (state_q == ST_RESP) ? cnt_q + BW'(1) : cnt_q;
    assign nb_s    = (state_q == ST_RESP) ? beat_q + BW'(1) : {BW{1'b0}};
    assign raddr_s = (cmd_q == CMD_READ) ? idx_q : {idx_q[AW-1:BW], rcnt_s};
    assign last_s  = (cmd_q != CMD_READ_BURST) || (beat_q == BW'(BEATS - 1));

    simplebus_mem_array #(.AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wmask_i (req_bits_wmask),
        .wdata_i (req_bits_wdata),
        .raddr_i (raddr_s),
        .rdata_o (rd_s)
    );

    // Next-state, memory write strobe and response-register loading.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        user_d       = user_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        resp_valid_d = resp_valid_q;
        resp_cmd_d   = resp_cmd_q;
        resp_rdata_d = resp_rdata_q;
        resp_user_d  = resp_user_q;
        we_s         = 1'b0;
        waddr_s      = req_idx_s;
        load_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    idx_d   = req_idx_s;
                    user_d  = req_bits_user;
                    beat_d  = {BW{1'b0}};
                    lat_d   = {LW{1'b0}};
                    state_d = ST_WAIT;
                    case (req_bits_cmd)
                        CMD_WRITE, CMD_WRITE_LAST: begin
                            we_s  = 1'b1;
                            cmd_d = CMD_WRITE;
                            cnt_d = {BW{1'b0}};
                        end
                        CMD_WRITE_BURST: begin
                            we_s    = 1'b1;
                            cmd_d   = CMD_WRITE_BURST;
                            cnt_d   = req_idx_s[BW-1:0] + BW'(1);
                            state_d = ST_WBURST;
                        end
                        CMD_READ_BURST: begin
                            cmd_d = CMD_READ_BURST;
                            cnt_d = req_idx_s[BW-1:0];
                        end
                        default: begin
                            cmd_d = req_bits_cmd;
                            cnt_d = {BW{1'b0}};
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WBURST: begin
                if (acc_s) begin
                    we_s    = 1'b1;
                    waddr_s = {idx_q[AW-1:BW], cnt_q};
                    cnt_d   = cnt_q + BW'(1);
                    lat_d   = {LW{1'b0}};
                    state_d = (req_bits_cmd == CMD_WRITE_BURST) ? ST_WBURST : ST_WAIT;
                end else begin
                    state_d = ST_WBURST;
                end
            end
            ST_WAIT: begin
                if (lat_q == LW'(LATENCY)) begin
                    state_d = ST_RESP;
                    load_s  = 1'b1;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_RESP: begin
                if (hs_s && last_s) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (hs_s) begin
                    beat_d = nb_s;
                    cnt_d  = rcnt_s;
                    load_s = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            resp_valid_d = 1'b1;
            resp_user_d  = user_q;
            resp_cmd_d   = resp_cmd_of(cmd_q, nb_s == BW'(BEATS - 1));
            resp_rdata_d = ((cmd_q == CMD_READ) || (cmd_q == CMD_READ_BURST)) ? rd_s : {DATA_W{1'b0}};
        end else begin
            resp_user_d = resp_user_d;
        end
    end

    assign req_ready_d = (state_d == ST_IDLE) || (state_d == ST_WBURST);

    // State, counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= {AW{1'b0}};
            cmd_q        <= 4'b0000;
            user_q       <= 16'h0000;
            cnt_q        <= {BW{1'b0}};
            beat_q       <= {BW{1'b0}};
            lat_q        <= {LW{1'b0}};
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_cmd_q   <= 4'b0000;
            resp_rdata_q <= 64'h0;
            resp_user_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cmd_q        <= cmd_d;
            user_q       <= user_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_cmd_q   <= resp_cmd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_user_q  <= resp_user_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_bits_cmd   = resp_cmd_q;
    assign resp_bits_rdata = resp_rdata_q;
    assign resp_bits_user  = resp_user_q;

endmodule

// File: tb/tb_simplebus_mem_slave.sv
// Bench for simplebus_mem_slave: one instance at LATENCY=2 and one at LATENCY=0,
// directed scenarios plus randomized traffic against a word-array reference model.
module tb_simplebus_mem_slave;
    import simplebus_pkg::*;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst        [2];
    logic        req_ready  [2];
    logic        req_valid  [2];
    logic [31:0] req_addr   [2];
    logic [2:0]  req_size   [2];
    logic [3:0]  req_cmd    [2];
    logic [7:0]  req_wmask  [2];
    logic [63:0] req_wdata  [2];
    logic [15:0] req_user   [2];
    logic        resp_ready [2];
    logic        resp_valid [2];
    logic [3:0]  resp_cmd   [2];
    logic [63:0] resp_rdata [2];
    logic [15:0] resp_user  [2];

    int total = 0;
    int bad   = 0;
    logic [63:0] mdl [2][1024];

    simplebus_mem_slave #(.AW(AW), .LATENCY(2), .BEATS(4)) u_lat2 (
        .clk(clk), .rst(rst[0]), .req_ready(req_ready[0]), .req_valid(req_valid[0]),
        .req_bits_addr(req_addr[0]), .req_bits_size(req_size[0]), .req_bits_cmd(req_cmd[0]),
        .req_bits_wmask(req_wmask[0]), .req_bits_wdata(req_wdata[0]), .req_bits_user(req_user[0]),
        .resp_ready(resp_ready[0]), .resp_valid(resp_valid[0]), .resp_bits_cmd(resp_cmd[0]),
        .resp_bits_rdata(resp_rdata[0]), .resp_bits_user(resp_user[0])
    );

    simplebus_mem_slave #(.AW(AW), .LATENCY(0), .BEATS(4)) u_lat0 (
        .clk(clk), .rst(rst[1]), .req_ready(req_ready[1]), .req_valid(req_valid[1]),
        .req_bits_addr(req_addr[1]), .req_bits_size(req_size[1]), .req_bits_cmd(req_cmd[1]),
        .req_bits_wmask(req_wmask[1]), .req_bits_wdata(req_wdata[1]), .req_bits_user(req_user[1]),
        .resp_ready(resp_ready[1]), .resp_valid(resp_valid[1]), .resp_bits_cmd(resp_cmd[1]),
        .resp_bits_rdata(resp_rdata[1]), .resp_bits_user(resp_user[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int idx_of(input logic [31:0] addr);
        return int'(addr[AW+2:3]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic mwrite(input int d, input int idx, input logic [7:0] mask, input logic [63:0] data);
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input logic [31:0] addr, input logic [3:0] cmd,
                        input logic [7:0] mask, input logic [63:0] wdata, input logic [15:0] user,
                        output int acc);
        int n;
        n = 0;
        req_addr[d]  = addr;
        req_cmd[d]   = cmd;
        req_wmask[d] = mask;
        req_wdata[d] = wdata;
        req_user[d]  = user;
        req_size[d]  = 3'($urandom_range(0, 3));
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("req_ready_timeout", 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        req_valid[d] = 1'b0;
    endtask

    task automatic recv_beat(input int d, input string tag, input logic [3:0] ecmd,
                             input logic [63:0] edata, input logic [15:0] euser,
                             input bit first, input int acc, input int stall);
        int n;
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < 40) begin
            chk({tag, "_req_ready_wait"}, 64'(req_ready[d]), 64'd0);
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk({tag, "_resp_timeout"}, 64'(resp_valid[d]), 64'd1);
            return;
        end
        if (first) chk({tag, "_latency"}, 64'(cyc - acc), 64'(lat_of(d) + 1));
        for (int s = 0; s <= stall; s++) begin
            resp_ready[d] = (s == stall);
            chk({tag, "_valid"}, 64'(resp_valid[d]), 64'd1);
            chk({tag, "_cmd"}, 64'(resp_cmd[d]), 64'(ecmd));
            chk({tag, "_rdata"}, resp_rdata[d], edata);
            chk({tag, "_user"}, 64'(resp_user[d]), 64'(euser));
            chk({tag, "_req_ready"}, 64'(req_ready[d]), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready[d] = 1'b0;
    endtask

    task automatic end_check(input int d, input string tag);
        chk({tag, "_end_valid"}, 64'(resp_valid[d]), 64'd0);
        chk({tag, "_end_ready"}, 64'(req_ready[d]), 64'd1);
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [3:0] cmd,
                            input logic [7:0] mask, input logic [63:0] data,
                            input logic [15:0] user, input int stall);
        int acc;
        send(d, addr, cmd, mask, data, user, acc);
        mwrite(d, idx_of(addr), mask, data);
        recv_beat(d, "write", 4'b0101, 64'd0, user, 1'b1, acc, stall);
        end_check(d, "write");
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [15:0] user, input int stall);
        int acc;
        send(d, addr, CMD_READ, 8'h00, 64'd0, user, acc);
        recv_beat(d, "read", 4'b0110, mdl[d][idx_of(addr)], user, 1'b1, acc, stall);
        end_check(d, "read");
    endtask

    task automatic do_unsup(input int d, input logic [31:0] addr, input logic [3:0] cmd, input logic [15:0] user);
        int acc;
        send(d, addr, cmd, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, user, acc);
        recv_beat(d, "unsup", 4'b1000, 64'd0, user, 1'b1, acc, int'($urandom_range(0, 2)));
        end_check(d, "unsup");
    endtask

    // Beats land at the wrapped positions of the aligned 4-word line, starting at addr.
    task automatic do_wburst(input int d, input logic [31:0] addr, input logic [63:0] data [4],
                             input logic [7:0] mask [4], input logic [3:0] last_cmd,
                             input logic [15:0] user);
        int acc, idx, base;
        idx  = idx_of(addr);
        base = idx & ~3;
        for (int k = 0; k < 4; k++) begin
            send(d, (k == 0) ? addr : $urandom, (k == 3) ? last_cmd : CMD_WRITE_BURST,
                 mask[k], data[k], user, acc);
            mwrite(d, base + ((idx + k) & 3), mask[k], data[k]);
            if (k < 3) chk("wburst_ready_mid", 64'(req_ready[d]), 64'd1);
        end
        recv_beat(d, "wburst", 4'b0101, 64'd0, user, 1'b1, acc, int'($urandom_range(0, 1)));
        end_check(d, "wburst");
    endtask

    task automatic do_rburst(input int d, input logic [31:0] addr, input logic [15:0] user,
                             input int stall_beat, input int stall_n);
        int acc, idx, base;
        idx  = idx_of(addr);
        base = idx & ~3;
        send(d, addr, CMD_READ_BURST, 8'h00, 64'd0, user, acc);
        for (int k = 0; k < 4; k++) begin
            recv_beat(d, "rburst", (k == 3) ? 4'b0110 : 4'b0000, mdl[d][base + ((idx + k) & 3)],
                      user, k == 0, acc, (k == stall_beat) ? stall_n : int'($urandom_range(0, 1)));
        end
        end_check(d, "rburst");
    endtask

    function automatic logic [31:0] rand_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[AW+2:3] = AW'(idx);
        return a;
    endfunction

    initial begin
        logic [63:0] dat [4];
        logic [7:0]  msk [4];
        logic [3:0]  lc;
        int acc;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'd0; req_size[d] = 3'd0;
            req_cmd[d] = 4'd0; req_wmask[d] = 8'd0; req_wdata[d] = 64'd0; req_user[d] = 16'd0;
            resp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 64'(req_ready[d]), 64'd1);
            chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
            chk("rst_resp_cmd", 64'(resp_cmd[d]), 64'd0);
            chk("rst_resp_rdata", resp_rdata[d], 64'd0);
            chk("rst_resp_user", 64'(resp_user[d]), 64'd0);
        end

        // Fill words 0..63 of both instances with wrapping full-mask bursts.
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < 16; l++) begin
                for (int k = 0; k < 4; k++) begin
                    dat[k] = {$urandom, $urandom};
                    msk[k] = 8'hFF;
                end
                do_wburst(d, rand_addr(4 * l + int'($urandom_range(0, 3))), dat, msk,
                          CMD_WRITE_LAST, 16'($urandom));
            end
        end

        // Directed scenarios on the LATENCY=2 instance.
        do_write(0, 32'h40, CMD_WRITE, 8'hFF, 64'h1122334455667788, 16'h000A, 0);
        do_read(0, 32'h40, 16'h000B, 0);
        do_write(0, 32'h48, CMD_WRITE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0001, 0);
        do_write(0, 32'h48, CMD_WRITE, 8'h0F, 64'h0, 16'h0002, 1);
        do_read(0, 32'h48, 16'h0003, 0);
        dat[0] = 64'hD0D0_0000_0000_00D0; dat[1] = 64'hD1D1_1111_1111_11D1;
        dat[2] = 64'hD2D2_2222_2222_22D2; dat[3] = 64'hD3D3_3333_3333_33D3;
        for (int k = 0; k < 4; k++) msk[k] = 8'hFF;
        do_wburst(0, 32'h80, dat, msk, CMD_WRITE_LAST, 16'h00C0);
        do_rburst(0, 32'h90, 16'h00C1, 0, 0);
        do_rburst(0, 32'h90, 16'h00C2, 1, 3);

        // Reset during beat 2 of a read burst drops the transaction.
        send(0, 32'h90, CMD_READ_BURST, 8'h00, 64'd0, 16'h005A, acc);
        recv_beat(0, "rst_burst", 4'b0000, mdl[0][18], 16'h005A, 1'b1, acc, 0);
        recv_beat(0, "rst_burst", 4'b0000, mdl[0][19], 16'h005A, 1'b0, acc, 0);
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_valid", 64'(resp_valid[0]), 64'd0);
        chk("midrst_ready", 64'(req_ready[0]), 64'd1);
        chk("midrst_cmd", 64'(resp_cmd[0]), 64'd0);
        chk("midrst_rdata", resp_rdata[0], 64'd0);
        do_read(0, 32'h98, 16'h0077, 1);

        // LATENCY=0 instance: immediate read and an unsupported command.
        do_read(1, 32'h10, 16'h0100, 0);
        do_unsup(1, 32'h18, 4'b1000, 16'h0101);
        do_write(1, 32'h20, CMD_WRITE_LAST, 8'hA5, 64'h0123_4567_89AB_CDEF, 16'h0102, 0);
        do_read(1, 32'h20, 16'h0103, 0);

        // Randomized traffic over words 0..63 with random backpressure.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60; i++) begin
                case ($urandom_range(0, 5))
                    0: do_write(d, rand_addr(int'($urandom_range(0, 63))),
                                ($urandom_range(0, 1) == 0) ? CMD_WRITE : CMD_WRITE_LAST,
                                8'($urandom), {$urandom, $urandom}, 16'($urandom),
                                int'($urandom_range(0, 2)));
                    2: begin
                        for (int k = 0; k < 4; k++) begin
                            dat[k] = {$urandom, $urandom};
                            msk[k] = 8'($urandom);
                        end
                        case ($urandom_range(0, 2))
                            0: lc = CMD_WRITE_LAST;
                            1: lc = CMD_READ;
                            default: lc = 4'hF;
                        endcase
                        do_wburst(d, rand_addr(int'($urandom_range(0, 63))), dat, msk, lc, 16'($urandom));
                    end
                    3: do_rburst(d, rand_addr(int'($urandom_range(0, 63))), 16'($urandom),
                                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    4: begin
                        lc = 4'($urandom_range(4, 15));
                        if (lc == CMD_WRITE_LAST) lc = 4'hC;
                        do_unsup(d, rand_addr(int'($urandom_range(0, 63))), lc, 16'($urandom));
                    end
                    default: do_read(d, rand_addr(int'($urandom_range(0, 63))), 16'($urandom),
                                     int'($urandom_range(0, 2)));
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
